// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle computer main controller.
// State codes, instruction field constants, ALU codes and the control bundle.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_ALU_WB  = 4'd5,
    S_MEM_ADR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WB  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_BRANCH  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  localparam logic [2:0] SHIFT_NONE = 3'b111;

  typedef struct packed {
    logic       a3_src;
    logic       adr_src;
    logic       flag_update;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       reg_write;
    logic       wd3_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] reg_src;
    logic [2:0] alu_op;
    logic [2:0] shift_type;
  } ctrl_t;

  localparam ctrl_t CTRL_INACTIVE = ctrl_t'({19'b0, SHIFT_NONE});

  function automatic logic [2:0] alu_op_of(input logic [3:0] cmd);
    logic [2:0] r;
    r = ALU_ADD;
    case (cmd)
      CMD_ADD: r = ALU_ADD;
      CMD_SUB: r = ALU_SUB;
      CMD_AND: r = ALU_AND;
      CMD_ORR: r = ALU_ORR;
      CMD_MOV: r = ALU_MOV;
      CMD_CMP: r = ALU_SUB;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic cmd_writes(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR) ||
           (cmd == CMD_MOV);
  endfunction

endpackage

// File: rtl/multicycle_computer_controller_cond.sv
// Combinational condition-code evaluator over the datapath {N,Z,C,V} flags.
// Code 1111 never passes.
module cond_check
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_computer_controller.sv
// Moore main control FSM for the multicycle computer datapath.
// Define MC_CTRL_BRANCH_LINK_EN to make BL write the return address to R14.
module multicycle_computer_controller
  import multicycle_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] INSTRUCTION,
  input  logic [3:0]  FLAGS,
  output logic        A3Src,
  output logic        AdrSrc,
  output logic        FlagUpdate,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        WD3Src,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUop,
  output logic [2:0]  ShiftType,
  output logic [3:0]  STATE_OUT
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic       cond_pass;
  logic       run;

  logic [3:0] cond;
  logic [1:0] op;
  logic       imm;
  logic [3:0] cmd;
  logic       s_bit;
  logic [4:0] sh_amt;
  logic [1:0] sh_type;
  logic       unused_bits;

  assign cond    = INSTRUCTION[31:28];
  assign op      = INSTRUCTION[27:26];
  assign imm     = INSTRUCTION[25];
  assign cmd     = INSTRUCTION[24:21];
  assign s_bit   = INSTRUCTION[20];
  assign sh_amt  = INSTRUCTION[11:7];
  assign sh_type = INSTRUCTION[6:5];

  assign unused_bits = ^{INSTRUCTION[19:12], INSTRUCTION[4:0]};

  cond_check u_cond (
    .cond  (cond),
    .flags (FLAGS),
    .pass  (cond_pass)
  );

  // Undefined ops are squashed exactly like a failed condition
  assign run = cond_pass && (op != OP_UNDEF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    ctrl      = CTRL_INACTIVE;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_b  = 2'b11;
        ctrl.result_src = 2'b10;
        ctrl.reg_src    = 2'b10;
        state_nxt       = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          !run:                 state_nxt = S_FETCH;
          run && op == OP_DP:   state_nxt = imm ? S_EXEC_I : S_EXEC_R;
          run && op == OP_MEM:  state_nxt = S_MEM_ADR;
          run && op == OP_BR:   state_nxt = S_BRANCH;
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_src_b   = 2'b00;
        ctrl.alu_op      = alu_op_of(cmd);
        ctrl.flag_update = s_bit;
        if (cmd == CMD_MOV && sh_amt != 5'd0)
          ctrl.shift_type = {1'b0, sh_type};
        state_nxt = cmd_writes(cmd) ? S_ALU_WB : S_FETCH;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_op      = alu_op_of(cmd);
        ctrl.flag_update = s_bit;
        state_nxt = cmd_writes(cmd) ? S_ALU_WB : S_FETCH;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_a  = 2'b01;
        ctrl.result_src = 2'b00;
        state_nxt       = S_FETCH;
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = s_bit ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.adr_src = 1'b1;
        state_nxt    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 2'b01;
        state_nxt       = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.reg_src   = 2'b10;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.reg_src    = 2'b01;
`ifdef MC_CTRL_BRANCH_LINK_EN
        if (INSTRUCTION[24]) begin
          ctrl.reg_write = 1'b1;
          ctrl.a3_src    = 1'b1;
          ctrl.wd3_src   = 1'b1;
        end
`endif
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign A3Src      = ctrl.a3_src;
  assign AdrSrc     = ctrl.adr_src;
  assign FlagUpdate = ctrl.flag_update;
  assign IRWrite    = ctrl.ir_write;
  assign MemWrite   = ctrl.mem_write;
  assign PCWrite    = ctrl.pc_write;
  assign RegWrite   = ctrl.reg_write;
  assign WD3Src     = ctrl.wd3_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign RegSrc     = ctrl.reg_src;
  assign ALUop      = ctrl.alu_op;
  assign ShiftType  = ctrl.shift_type;
  assign STATE_OUT  = state;

endmodule

// File: tb/tb_multicycle_computer_controller.sv
// Self-checking bench for the multicycle computer controller.
// Table vectors, reset corner cases and random instructions vs a reference model.
module tb_multicycle_computer_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] INSTRUCTION;
  logic [3:0]  FLAGS;
  logic        A3Src, AdrSrc, FlagUpdate, IRWrite;
  logic        MemWrite, PCWrite, RegWrite, WD3Src;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
  logic [2:0]  ALUop, ShiftType;
  logic [3:0]  STATE_OUT;

  multicycle_computer_controller dut (
    .clock       (clock),
    .reset       (reset),
    .INSTRUCTION (INSTRUCTION),
    .FLAGS       (FLAGS),
    .A3Src       (A3Src),
    .AdrSrc      (AdrSrc),
    .FlagUpdate  (FlagUpdate),
    .IRWrite     (IRWrite),
    .MemWrite    (MemWrite),
    .PCWrite     (PCWrite),
    .RegWrite    (RegWrite),
    .WD3Src      (WD3Src),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ResultSrc   (ResultSrc),
    .RegSrc      (RegSrc),
    .ALUop       (ALUop),
    .ShiftType   (ShiftType),
    .STATE_OUT   (STATE_OUT)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       a3, adr, fu, irw, mw, pcw, rw, wd3;
    logic [1:0] srca, srcb, res, regsrc;
    logic [2:0] aluop, shift;
  } ov_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  f;
    int          cpi;
    bit          rw;
    bit          mw;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  function automatic ov_t actual();
    return {A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite,
            RegWrite, WD3Src, ALUSrcA, ALUSrcB, ResultSrc, RegSrc,
            ALUop, ShiftType};
  endfunction

  function automatic ov_t idle_vec();
    ov_t o;
    o = '0;
    o.shift = 3'b111;
    return o;
  endfunction

  function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // cmd -> {writes register, ALU code}; unknown commands add without writeback
  function automatic logic [3:0] ref_cmd(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return {1'b1, 3'd0};
      4'b0010: return {1'b1, 3'd1};
      4'b0000: return {1'b1, 3'd2};
      4'b1100: return {1'b1, 3'd3};
      4'b1101: return {1'b1, 3'd4};
      4'b1010: return {1'b0, 3'd1};
      default: return {1'b0, 3'd0};
    endcase
  endfunction

  function automatic ov_t exp_out(input logic [3:0] st, input logic [31:0] ins);
    ov_t o;
    logic [3:0] cm;
    o  = idle_vec();
    cm = ref_cmd(ins[24:21]);
    case (st)
      4'd1: begin o.irw = 1; o.pcw = 1; o.srcb = 3; o.res = 2; o.regsrc = 2; end
      4'd3: begin
        o.srca = 2; o.srcb = 0; o.aluop = cm[2:0]; o.fu = ins[20];
        if (ins[24:21] == 4'b1101 && ins[11:7] != 0) o.shift = {1'b0, ins[6:5]};
      end
      4'd4: begin o.srca = 2; o.srcb = 1; o.aluop = cm[2:0]; o.fu = ins[20]; end
      4'd5: begin o.rw = 1; o.srca = 1; end
      4'd6: begin o.srca = 2; o.srcb = 1; end
      4'd7: o.adr = 1;
      4'd8: begin o.rw = 1; o.res = 1; end
      4'd9: begin o.adr = 1; o.mw = 1; o.regsrc = 2; end
      4'd10: begin
        o.pcw = 1; o.srcb = 2; o.res = 2; o.regsrc = 1;
`ifdef MC_CTRL_BRANCH_LINK_EN
        if (ins[24]) begin o.rw = 1; o.a3 = 1; o.wd3 = 1; end
`endif
      end
      default: ;
    endcase
    return o;
  endfunction

  // Expected state codes visited after FETCH, ending with the next FETCH
  task automatic build_seq(input logic [31:0] ins, input logic [3:0] f);
    logic [3:0] cm;
    exp_q = {};
    exp_q.push_back(4'd2);
    cm = ref_cmd(ins[24:21]);
    if (!ref_cond(ins[31:28], f) || ins[27:26] == 2'b11) begin
      exp_q.push_back(4'd1);
      return;
    end
    case (ins[27:26])
      2'b00: begin
        exp_q.push_back(ins[25] ? 4'd4 : 4'd3);
        if (cm[3]) exp_q.push_back(4'd5);
      end
      2'b01: begin
        exp_q.push_back(4'd6);
        if (ins[20]) begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); end
        else exp_q.push_back(4'd9);
      end
      default: exp_q.push_back(4'd10);
    endcase
    exp_q.push_back(4'd1);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Call at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] f,
                           output int cycles, output bit saw_rw,
                           output bit saw_mw);
    check("pre_fetch", 32'(STATE_OUT), 32'd1);
    INSTRUCTION = ins;
    FLAGS       = f;
    build_seq(ins, f);
    cycles = 0;
    saw_rw = 0;
    saw_mw = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clock);
      #1;
      check("state", 32'(STATE_OUT), 32'(exp_q[i]));
      check("outputs", 32'(actual()), 32'(exp_out(exp_q[i], ins)));
      if (RegWrite) saw_rw = 1;
      if (MemWrite) saw_mw = 1;
      if (STATE_OUT == 4'd1 && cycles == 0) cycles = i + 1;
      if (exp_q[i] >= 4'd3) begin
        FLAGS = 4'($urandom);
        #1;
        check("flags_iso", 32'(actual()), 32'(exp_out(exp_q[i], ins)));
      end
    end
    if (cycles == 0) cycles = 99;
    @(negedge clock);
  endtask

  vec_t tbl[12];
  int   cyc;
  bit   rw, mw;
  logic [3:0] cmds[8];

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'hE3A0000D, 4'b0000, 4, 1, 0};
    tbl[1]  = '{32'hE1500001, 4'b0000, 3, 0, 0};
    tbl[2]  = '{32'h03A0000D, 4'b0000, 2, 0, 0};
    tbl[3]  = '{32'h03A0000D, 4'b0100, 4, 1, 0};
    tbl[4]  = '{32'hE5901004, 4'b0000, 5, 1, 0};
    tbl[5]  = '{32'hE5801004, 4'b0000, 4, 0, 1};
`ifdef MC_CTRL_BRANCH_LINK_EN
    tbl[6]  = '{32'hEB000002, 4'b0000, 3, 1, 0};
`else
    tbl[6]  = '{32'hEB000002, 4'b0000, 3, 0, 0};
`endif
    tbl[7]  = '{32'hEC000000, 4'b0000, 2, 0, 0};
    tbl[8]  = '{32'hE1A00141, 4'b0000, 4, 1, 0};
    tbl[9]  = '{32'hE0200001, 4'b0000, 3, 0, 0};
    tbl[10] = '{32'hE2900001, 4'b0000, 4, 1, 0};
    tbl[11] = '{32'hC3A0000D, 4'b1000, 2, 0, 0};

    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1101; cmds[5] = 4'b1010;
    cmds[6] = 4'b0001; cmds[7] = 4'b1111;

    reset       = 1'b1;
    INSTRUCTION = 32'h0;
    FLAGS       = 4'h0;
    #1;
    check("reset_state", 32'(STATE_OUT), 32'd0);
    check("reset_outputs", 32'(actual()), 32'(idle_vec()));
    @(negedge clock);
    @(negedge clock);
    check("idle_hold", 32'(STATE_OUT), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("first_fetch", 32'(STATE_OUT), 32'd1);
    check("fetch_outputs", 32'(actual()), 32'(exp_out(4'd1, 32'h0)));
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].ins, tbl[i].f, cyc, rw, mw);
      check($sformatf("cpi[%0d]", i), 32'(cyc), 32'(tbl[i].cpi));
      check($sformatf("regwrite[%0d]", i), 32'(rw), 32'(tbl[i].rw));
      check($sformatf("memwrite[%0d]", i), 32'(mw), 32'(tbl[i].mw));
    end

    // Reset mid-store must kill MemWrite asynchronously
    check("pre_str", 32'(STATE_OUT), 32'd1);
    INSTRUCTION = 32'hE5801004;
    FLAGS       = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    check("mem_wr_state", 32'(STATE_OUT), 32'd9);
    check("mem_wr_write", 32'(MemWrite), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_state", 32'(STATE_OUT), 32'd0);
    check("rst_outputs", 32'(actual()), 32'(idle_vec()));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_refetch", 32'(STATE_OUT), 32'd1);
    @(negedge clock);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      ins        = $urandom;
      ins[24:21] = cmds[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      run_instr(ins, 4'($urandom), cyc, rw, mw);
      check("rand_cpi", 32'(cyc), 32'(exp_q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
